// File: rtl/mips_pkg.sv
// Opcode, funct, mnemonic and loader-state encodings shared by the control unit and the instruction loader.
// Also holds the field-packing helpers for the R and I formats.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Codes 14 and 15 are deliberately left unnamed; they are the invalid mnemonics.
    typedef enum logic [3:0] {
        MN_NOP  = 4'd0,
        MN_ADD  = 4'd1,
        MN_SUB  = 4'd2,
        MN_AND  = 4'd3,
        MN_OR   = 4'd4,
        MN_SLT  = 4'd5,
        MN_ADDI = 4'd6,
        MN_ANDI = 4'd7,
        MN_ORI  = 4'd8,
        MN_SLTI = 4'd9,
        MN_LW   = 4'd10,
        MN_SW   = 4'd11,
        MN_BEQ  = 4'd12,
        MN_J    = 4'd13
    } mnem_e;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FULL  = 2'd1,
        ST_ERROR = 2'd2
    } ld_state_e;

    function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {OP_RTYPE, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_word_encode.sv
// Purpose: assemble a 32-bit MIPS R/I/J word from a mnemonic and its fields.
// Latency: purely combinational.
// Backpressure: none; valid_op flags mnemonics 14-15 as unencodable.
module mips_word_encode
    import mips_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        valid_op
);

    always_comb begin
        word     = 32'h0;
        valid_op = 1'b1;
        case (mnem)
            MN_NOP:  word = 32'h0;
            MN_ADD:  word = enc_r(FN_ADD, rs, rt, rd);
            MN_SUB:  word = enc_r(FN_SUB, rs, rt, rd);
            MN_AND:  word = enc_r(FN_AND, rs, rt, rd);
            MN_OR:   word = enc_r(FN_OR,  rs, rt, rd);
            MN_SLT:  word = enc_r(FN_SLT, rs, rt, rd);
            MN_ADDI: word = enc_i(OP_ADDI, rs, rt, imm);
            MN_ANDI: word = enc_i(OP_ANDI, rs, rt, imm);
            MN_ORI:  word = enc_i(OP_ORI,  rs, rt, imm);
            MN_SLTI: word = enc_i(OP_SLTI, rs, rt, imm);
            MN_LW:   word = enc_i(OP_LW,   rs, rt, imm);
            MN_SW:   word = enc_i(OP_SW,   rs, rt, imm);
            MN_BEQ:  word = enc_i(OP_BEQ,  rs, rt, imm);
            MN_J:    word = {OP_J, target};
            default: valid_op = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Purpose: encode one MIPS instruction per handshake and write it to the next instruction-memory word.
// Latency: 1 cycle from transfer to mem_we/mem_addr/mem_wdata; sustains 1 word/cycle.
// Backpressure: in_ready drops when memory is full, after an invalid mnemonic, or while clear is high.
module instr_encode_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int             DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

    ld_state_e   state;
    ld_state_e   state_nxt;
    logic [31:0] enc_word;
    logic        enc_valid;
    logic        xfer;
    logic        wr_ok;

    mips_word_encode u_encode (
        .mnem     (in_mnem),
        .rs       (in_rs),
        .rt       (in_rt),
        .rd       (in_rd),
        .imm      (in_imm),
        .target   (in_target),
        .word     (enc_word),
        .valid_op (enc_valid)
    );

    assign xfer  = in_valid && in_ready;
    assign wr_ok = xfer && enc_valid;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // FULL and ERROR are sticky; only clear or rst (handled above) returns to LOAD.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (xfer) begin
                    if (!enc_valid) begin
                        state_nxt = ST_ERROR;
                    end else if (count == LAST_COUNT) begin
                        state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL:  state_nxt = ST_FULL;
            ST_ERROR: state_nxt = ST_ERROR;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_LOAD) && !clear;
        full     = (state == ST_FULL);
        err      = (state == ST_ERROR);
    end

    // Address and data hold between writes so the memory side can latch them lazily.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else begin
            mem_we <= wr_ok;
            if (clear) begin
                count <= '0;
            end else if (wr_ok) begin
                count <= count + 1'b1;
            end
            if (wr_ok) begin
                mem_addr  <= count[ADDR_W-1:0];
                mem_wdata <= enc_word;
            end
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: a 64-word and a 4-word instance share one stimulus stream,
// directed scenarios use literal expected words, the random run uses a behavioural model.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid;
    logic [3:0]  in_mnem;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        rdy_a, we_a, full_a, err_a;
    logic [5:0]  addr_a;
    logic [31:0] wdata_a;
    logic [6:0]  count_a;

    logic        rdy_b, we_b, full_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_W(6)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .count(count_a), .full(full_a), .err(err_a)
    );

    instr_encode_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy_b),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .count(count_b), .full(full_b), .err(err_b)
    );

    // Reference encoder: the instruction-set table written as plain arithmetic.
    function automatic logic [31:0] ref_word(int m, int rs, int rt, int rd, int imm, int tgt);
        longint w;
        int     code;
        w = 0;
        code = 0;
        if (m >= 1 && m <= 5) begin
            case (m)
                1: code = 32; 2: code = 34; 3: code = 36; 4: code = 37; default: code = 42;
            endcase
            w = longint'(rs) * (1 << 21) + longint'(rt) * (1 << 16) + longint'(rd) * (1 << 11) + code;
        end else if (m >= 6 && m <= 12) begin
            case (m)
                6: code = 8; 7: code = 12; 8: code = 13; 9: code = 10;
                10: code = 35; 11: code = 43; default: code = 4;
            endcase
            w = longint'(code) * (longint'(1) << 26) + longint'(rs) * (1 << 21)
                + longint'(rt) * (1 << 16) + imm;
        end else if (m == 13) begin
            w = 2 * (longint'(1) << 26) + tgt;
        end
        return 32'(w);
    endfunction

    int          depth_m[2] = '{64, 4};
    int          m_count[2];
    bit          m_full[2], m_err[2], m_we[2];
    int          m_addr[2];
    logic [31:0] m_wdata[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_count[d] = 0; m_full[d] = 0; m_err[d] = 0; m_we[d] = 0; m_addr[d] = 0; m_wdata[d] = 0;
        end
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit rdy;
            rdy = !m_full[d] && !m_err[d] && !clear;
            if (rst) begin
                m_count[d] = 0; m_full[d] = 0; m_err[d] = 0; m_we[d] = 0; m_addr[d] = 0; m_wdata[d] = 0;
            end else if (clear) begin
                m_count[d] = 0; m_full[d] = 0; m_err[d] = 0; m_we[d] = 0;
            end else if (in_valid && rdy) begin
                if (in_mnem > 13) begin
                    m_err[d] = 1; m_we[d] = 0;
                end else begin
                    m_we[d]    = 1;
                    m_addr[d]  = m_count[d];
                    m_wdata[d] = ref_word(in_mnem, in_rs, in_rt, in_rd, in_imm, in_target);
                    m_count[d]++;
                    if (m_count[d] == depth_m[d]) m_full[d] = 1;
                end
            end else begin
                m_we[d] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int m, int rs, int rt, int rd, int imm, int tgt);
        in_mnem = 4'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = 16'(imm); in_target = 26'(tgt);
    endtask

    task automatic pulse_clear();
        in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        n_checks++; if (we_a !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", we_a); end
        n_checks++; if (addr_a !== 6'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", addr_a); end
        n_checks++; if (wdata_a !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", wdata_a); end
        n_checks++; if (count_a !== 7'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_a); end
        n_checks++; if ({full_a, err_a} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {full_a, err_a}); end
        n_checks++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", rdy_a); end
    endtask

    task automatic test_single_add();
        drive(1, 1, 2, 3, 0, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (we_a !== 1'b1) begin n_fail++; $display("FAIL add_we got %b want 1", we_a); end
        n_checks++; if (addr_a !== 6'd0) begin n_fail++; $display("FAIL add_addr got %0d want 0", addr_a); end
        n_checks++; if (wdata_a !== 32'h00221820) begin n_fail++; $display("FAIL add_wdata got %h want 00221820", wdata_a); end
        n_checks++; if (count_a !== 7'd1) begin n_fail++; $display("FAIL add_count got %0d want 1", count_a); end
        tick();
        n_checks++; if (we_a !== 1'b0) begin n_fail++; $display("FAIL add_idle_we got %b want 0", we_a); end
        n_checks++; if (wdata_a !== 32'h00221820) begin n_fail++; $display("FAIL add_hold_wdata got %h want 00221820", wdata_a); end
    endtask

    task automatic test_back_to_back();
        int          mn[6]  = '{6, 10, 11, 12, 13, 5};
        int          rs[6]  = '{0, 29, 29, 1, 0, 5};
        int          rt[6]  = '{8, 9, 9, 2, 0, 6};
        int          rd[6]  = '{0, 0, 0, 0, 0, 4};
        int          imm[6] = '{5, 4, 8, 'hFFFF, 0, 0};
        int          tg[6]  = '{0, 0, 0, 0, 'h10, 0};
        logic [31:0] exp[6] = '{32'h20080005, 32'h8FA90004, 32'hAFA90008,
                                32'h1022FFFF, 32'h08000010, 32'h00A6202A};
        pulse_clear();
        for (int i = 0; i < 6; i++) begin
            drive(mn[i], rs[i], rt[i], rd[i], imm[i], tg[i]);
            in_valid = 1'b1;
            tick();
            n_checks++; if (we_a !== 1'b1) begin n_fail++; $display("FAIL b2b_we[%0d] got %b want 1", i, we_a); end
            n_checks++; if (addr_a !== 6'(i)) begin n_fail++; $display("FAIL b2b_addr[%0d] got %0d want %0d", i, addr_a, i); end
            n_checks++; if (wdata_a !== exp[i]) begin n_fail++; $display("FAIL b2b_wdata[%0d] got %h want %h", i, wdata_a, exp[i]); end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (we_a !== 1'b0) begin n_fail++; $display("FAIL b2b_end_we got %b want 0", we_a); end
        n_checks++; if (count_a !== 7'd6) begin n_fail++; $display("FAIL b2b_count got %0d want 6", count_a); end
    endtask

    task automatic test_fill();
        pulse_clear();
        drive(0, 7, 7, 7, 7, 7);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (we_b !== 1'b1) begin n_fail++; $display("FAIL fill_we[%0d] got %b want 1", i, we_b); end
            n_checks++; if (addr_b !== 2'(i)) begin n_fail++; $display("FAIL fill_addr[%0d] got %0d want %0d", i, addr_b, i); end
            n_checks++; if (full_b !== (i == 3)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, full_b, i == 3); end
        end
        n_checks++; if (rdy_b !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %b want 0", rdy_b); end
        n_checks++; if (wdata_b !== 32'h0) begin n_fail++; $display("FAIL fill_wdata got %h want 0", wdata_b); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (we_b !== 1'b0) begin n_fail++; $display("FAIL fill_hold_we[%0d] got %b want 0", i, we_b); end
            n_checks++; if (count_b !== 3'd4) begin n_fail++; $display("FAIL fill_hold_count[%0d] got %0d want 4", i, count_b); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_invalid();
        pulse_clear();
        in_valid = 1'b1;
        drive(1, 1, 2, 3, 0, 0); tick();
        drive(2, 4, 5, 6, 0, 0); tick();
        drive(14, 1, 1, 1, 1, 1); tick();
        n_checks++; if (we_a !== 1'b0) begin n_fail++; $display("FAIL inv_we got %b want 0", we_a); end
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL inv_err got %b want 1", err_a); end
        n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL inv_ready got %b want 0", rdy_a); end
        n_checks++; if (count_a !== 7'd2) begin n_fail++; $display("FAIL inv_count got %0d want 2", count_a); end
        n_checks++; if (addr_a !== 6'd1) begin n_fail++; $display("FAIL inv_addr got %0d want 1", addr_a); end
        in_valid = 1'b0;
        clear = 1'b1;
        #1;
        n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL inv_clr_ready got %b want 0", rdy_a); end
        tick();
        clear = 1'b0;
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL inv_clr_err got %b want 0", err_a); end
        n_checks++; if (count_a !== 7'd0) begin n_fail++; $display("FAIL inv_clr_count got %0d want 0", count_a); end
        drive(1, 1, 2, 3, 0, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if ({we_a, addr_a} !== {1'b1, 6'd0}) begin n_fail++; $display("FAIL inv_recover got we=%b addr=%0d want we=1 addr=0", we_a, addr_a); end
    endtask

    task automatic test_clear_and_rst();
        pulse_clear();
        drive(1, 1, 2, 3, 0, 0);
        in_valid = 1'b1;
        tick();
        clear = 1'b1;
        #1;
        n_checks++; if (we_a !== 1'b1) begin n_fail++; $display("FAIL clr_pending_we got %b want 1", we_a); end
        n_checks++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL clr_ready got %b want 0", rdy_a); end
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (we_a !== 1'b0) begin n_fail++; $display("FAIL clr_we got %b want 0", we_a); end
        n_checks++; if (count_a !== 7'd0) begin n_fail++; $display("FAIL clr_count got %0d want 0", count_a); end
        n_checks++; if (wdata_a !== 32'h00221820) begin n_fail++; $display("FAIL clr_hold_wdata got %h want 00221820", wdata_a); end
        in_valid = 1'b1;
        drive(1, 1, 2, 3, 0, 0); tick();
        drive(13, 0, 0, 0, 0, 'h123); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (we_a !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b want 0", we_a); end
        n_checks++; if ({addr_a, wdata_a} !== 38'h0) begin n_fail++; $display("FAIL rst_addr_wdata got %0d/%h want 0/0", addr_a, wdata_a); end
        n_checks++; if ({count_a, full_a, err_a} !== 9'h0) begin n_fail++; $display("FAIL rst_count_flags got %0d/%b/%b want 0/0/0", count_a, full_a, err_a); end
    endtask

    task automatic test_random();
        logic        got_rdy[2], got_we[2], got_full[2], got_err[2];
        int          got_addr[2], got_count[2];
        logic [31:0] got_wdata[2];
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 149) == 0);
            clear    = ($urandom_range(0, 24) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 19) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 13),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFFFF));
            #1;
            got_rdy[0] = rdy_a; got_rdy[1] = rdy_b;
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (got_rdy[d] !== (!m_full[d] && !m_err[d] && !clear)) begin
                    n_fail++; $display("FAIL rnd_ready[%0d] cyc %0d got %b want %b", d, c, got_rdy[d], !m_full[d] && !m_err[d] && !clear);
                end
            end
            model_edge();
            tick();
            got_we[0] = we_a; got_we[1] = we_b;
            got_addr[0] = int'(addr_a); got_addr[1] = int'(addr_b);
            got_wdata[0] = wdata_a; got_wdata[1] = wdata_b;
            got_count[0] = int'(count_a); got_count[1] = int'(count_b);
            got_full[0] = full_a; got_full[1] = full_b;
            got_err[0] = err_a; got_err[1] = err_b;
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (got_we[d] !== m_we[d] || got_addr[d] != m_addr[d] || got_wdata[d] !== m_wdata[d]) begin
                    n_fail++; $display("FAIL rnd_write[%0d] cyc %0d got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                                       d, c, got_we[d], got_addr[d], got_wdata[d], m_we[d], m_addr[d], m_wdata[d]);
                end
                n_checks++;
                if (got_count[d] != m_count[d] || got_full[d] !== m_full[d] || got_err[d] !== m_err[d]) begin
                    n_fail++; $display("FAIL rnd_status[%0d] cyc %0d got count=%0d full=%b err=%b want count=%0d full=%b err=%b",
                                       d, c, got_count[d], got_full[d], got_err[d], m_count[d], m_full[d], m_err[d]);
                end
            end
        end
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_fill();
        test_invalid();
        test_clear_and_rst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
Encoder and loader for the MIPS instruction formats that the control unit decodes. It accepts one instruction at a time as a mnemonic plus fields over a valid/ready handshake and assembles the 32-bit R, I or J-format word. It then writes that word into sequential instruction-memory addresses. It is used by the bring-up and test infrastructure to fill instruction memory before the core is released from reset.

Parameters:
ADDR_W, 6, instruction-memory word-address width; DEPTH = 2**ADDR_W words.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
clear  in  1  sync restart: address/count/error to 0, highest priority after rst
in_valid  in  1  instruction request valid
in_ready  out  1  block can accept a request this cycle
in_mnem  in  4  mnemonic: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 ADDI, 7 ANDI, 8 ORI, 9 SLTI, 10 LW, 11 SW, 12 BEQ, 13 J, 14-15 invalid
in_rs  in  5  source register
in_rt  in  5  second source (R/SW/BEQ) or destination (ADDI/ANDI/ORI/SLTI/LW)
in_rd  in  5  R-type destination
in_imm  in  16  immediate / offset, inserted raw
in_target  in  26  J word target
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  encoded instruction
count  out  ADDR_W+1  words accepted since reset/clear
full  out  1  DEPTH words accepted
err  out  1  sticky: invalid mnemonic received

Behaviour:
- Reset values (rst=1 at an edge): state LOAD, count=0, mem_we=0, mem_addr=0, mem_wdata=0, full=0, err=0.
- Handshake: transfer occurs when in_valid && in_ready at a rising edge. Fields are sampled only at transfer. in_valid may be held without transfer.
- in_ready = (state==LOAD) && !clear (combinational from state and clear).
- Latency 1. In the cycle after a valid transfer:
  - mem_we=1
  - mem_addr = count value at transfer
  - mem_wdata = encoded word
  Otherwise mem_we=0, and mem_addr/mem_wdata hold their last value.
- Back-to-back transfers sustain 1 word/cycle.
- Encoding:
  - R-type: {6'h00, rs, rt, rd, 5'h0, funct}, with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - I-type: {op, rs, rt, imm}, with op ADDI 0x08, ANDI 0x0C, ORI 0x0D, SLTI 0x0A, LW 0x23, SW 0x2B, BEQ 0x04.
  - J: {6'h02, target}.
  - NOP: 32'h0.
  - Fields unused by a format are ignored.
- FSM states:
  - LOAD: valid transfer → count+1. If the new count==DEPTH, go to FULL. Invalid-mnemonic transfer → no write, count unchanged, err=1, go to ERROR.
  - FULL: full=1, in_ready=0. Leave only via clear or rst.
  - ERROR: err=1, in_ready=0. Leave only via clear or rst.
- clear=1 at an edge:
  - go to LOAD
  - count=0, full=0, err=0
  - mem_we=0 next cycle
  - no transfer in that cycle (in_ready=0)
  - mem_addr/mem_wdata hold
- A write already registered before a clear edge is presented normally in the cycle clear is asserted.
- rst has priority over clear. rst mid-sequence cancels any write that would appear the following cycle.
- Boundary: the transfer that makes count==DEPTH writes address DEPTH-1. full asserts the same cycle that write appears.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J)
  - funct constants
  - mnemonic encodings 0-13
  - FSM state encodings
  The control unit and this block share these constants.
- Sub-module mips_word_encode: purely combinational (mnem, rs, rt, rd, imm, target) → (word, valid_op). The top holds the FSM, counter and output registers.

Test Plan:
- Reset, then ADD rd=3 rs=1 rt=2 → next cycle mem_we=1, addr=0, wdata=0x00221820; count=1.
- Back-to-back transfers:
  - ADDI rt=8 rs=0 imm=5 → 0x20080005 at addr 0
  - LW rt=9 rs=29 imm=4 → 0x8FA90004 at addr 1
  - SW rt=9 rs=29 imm=8 → 0xAFA90008 at addr 2
  - BEQ rs=1 rt=2 imm=0xFFFF → 0x1022FFFF at addr 3
  - J target=0x10 → 0x08000010 at addr 4
  - SLT rd=4 rs=5 rt=6 → 0x00A6202A at addr 5
  mem_we high on 6 consecutive cycles.
- Fill with ADDR_W=2, 4 NOPs → writes at addrs 0-3; full=1 and in_ready=0 from the 4th write cycle; 5th in_valid held 3 cycles → no write.
- in_mnem=14 after 2 good words → no write; err=1, in_ready=0, count=2; clear pulse → err=0, count=0, next ADD writes addr 0.
- clear and in_valid in the same cycle → no transfer, no write next cycle. rst asserted the cycle after a transfer → mem_we=0 next cycle, all outputs at reset values.
